// File: rtl/fetch_queue_if.sv
// Fetch-to-memory/decode bundle: PC in, imem read port, decode handshake.
// slave = fetch stage, master = PC/memory/decode environment.
interface fetch_queue_if #(
  parameter int NBITS  = 8,
  parameter int DWIDTH = 32
);
  logic [NBITS-1:0]  pc;
  logic              pc_enable;
  logic              imem_rd;
  logic [NBITS-1:0]  imem_addr;
  logic [DWIDTH-1:0] imem_rdata;
  logic              flush;
  logic              instr_valid;
  logic              instr_ready;
  logic [DWIDTH-1:0] instr_data;
  logic [NBITS-1:0]  instr_pc;

  modport slave (
    input  pc,
    input  imem_rdata,
    input  flush,
    input  instr_ready,
    output pc_enable,
    output imem_rd,
    output imem_addr,
    output instr_valid,
    output instr_data,
    output instr_pc
  );

  modport master (
    output pc,
    output imem_rdata,
    output flush,
    output instr_ready,
    input  pc_enable,
    input  imem_rd,
    input  imem_addr,
    input  instr_valid,
    input  instr_data,
    input  instr_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: credit-limited imem issue, {instr,pc} FIFO toward decode.
// Ports: clk, reset (sync, high), bus (fetch_queue_if.slave). Option: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int NBITS  = 8,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic              r_inflight;
  logic [NBITS-1:0]  r_inflight_pc;
  logic [DWIDTH-1:0] r_data [DEPTH];
  logic [NBITS-1:0]  r_pc   [DEPTH];

  logic [CW-1:0] w_credit;
  logic          w_empty;
  logic          w_issue;
  logic          w_resp;
  logic          w_byp;
  logic          w_push;
  logic          w_pop;

  assign w_empty  = (r_count == '0);
  // queued + outstanding; at most DEPTH
  assign w_credit = r_count + CW'(r_inflight);
  assign w_issue  = !reset && !bus.flush
                  && (w_credit < CW'(DEPTH));
  assign w_resp   = r_inflight && !bus.flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_resp && w_empty;
`else
  assign w_byp = 1'b0;
`endif

  // a bypassed word taken by decode is never written
  assign w_pop  = !w_empty && bus.instr_ready;
  assign w_push = w_resp && !(w_byp && bus.instr_ready);

  assign bus.pc_enable   = w_issue;
  assign bus.imem_rd     = w_issue;
  assign bus.imem_addr   = bus.pc;
  assign bus.instr_valid = !w_empty || w_byp;

  always_comb begin
    bus.instr_data = '0;
    bus.instr_pc   = '0;
    if (!w_empty) begin
      bus.instr_data = r_data[r_rptr];
      bus.instr_pc   = r_pc[r_rptr];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (w_byp) begin
      bus.instr_data = bus.imem_rdata;
      bus.instr_pc   = r_inflight_pc;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.flush) begin
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue)
        r_inflight_pc <= bus.pc;
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_data[r_wptr] <= bus.imem_rdata;
      r_pc[r_wptr]   <= r_inflight_pc;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
      !(w_push && r_count == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model, directed + random.
// Build with FETCH_QUEUE_BYPASS_EN to check the bypass variant.
module tb_fetch_queue;
  localparam int NB = 8;
  localparam int DW = 32;
  localparam int DP = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic [NB-1:0] p;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_queue_if #(.NBITS(NB), .DWIDTH(DW)) bus();

  fetch_queue #(.NBITS(NB), .DWIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model: queue of entries plus one outstanding fetch
  ent_t          q[$];
  bit            pend;
  logic [NB-1:0] pend_pc;

  // environment: PC register and 1-cycle memory
  logic [DW-1:0] mem [256];
  logic [NB-1:0] pc_r;
  bit            rd_q;
  logic [NB-1:0] addr_q;

  int n_chk, n_pass, n_fail;
  int cyc, fv, n_iss;
  logic [NB-1:0] acc[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit rdy);
    bit            e_iss, e_val, e_byp, o_rd;
    logic [DW-1:0] e_d;
    logic [NB-1:0] e_p, o_a;
    reset           = r;
    bus.flush       = f;
    bus.instr_ready = rdy;
    bus.pc          = pc_r;
    bus.imem_rdata  = rd_q ? mem[addr_q] : DW'($urandom);
    e_iss = !r && !f && (q.size() + int'(pend) < DP);
    e_byp = BYP && pend && !f && q.size() == 0;
    e_val = q.size() != 0 || e_byp;
    e_d   = '0;
    e_p   = '0;
    if (q.size() != 0) begin
      e_d = q[0].d;
      e_p = q[0].p;
    end else if (e_byp) begin
      e_d = bus.imem_rdata;
      e_p = pend_pc;
    end
    #4;
    chk("pc_enable", 64'(bus.pc_enable), 64'(e_iss));
    chk("imem_rd", 64'(bus.imem_rd), 64'(e_iss));
    chk("imem_addr", 64'(bus.imem_addr), 64'(pc_r));
    chk("instr_valid", 64'(bus.instr_valid), 64'(e_val));
    chk("instr_data", 64'(bus.instr_data), 64'(e_d));
    chk("instr_pc", 64'(bus.instr_pc), 64'(e_p));
    if (bus.instr_valid === 1'b1 && rdy && !r && !f)
      acc.push_back(bus.instr_pc);
    if (bus.instr_valid === 1'b1 && fv < 0)
      fv = cyc;
    o_rd = bus.imem_rd;
    o_a  = bus.imem_addr;
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      if (e_val && rdy && q.size() != 0)
        void'(q.pop_front());
      if (pend && !(e_byp && rdy))
        q.push_back('{d: bus.imem_rdata, p: pend_pc});
    end
    pend    = e_iss;
    pend_pc = pc_r;
    rd_q    = o_rd;
    addr_q  = o_a;
    if (o_rd) begin
      pc_r++;
      n_iss++;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    pc_r = '0;
    step(1'b1, 1'b0, 1'b0);
    pc_r = '0;
    cyc  = 0;
    fv   = -1;
    acc.delete();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    cyc = 0; fv = -1; n_iss = 0;
    pend = 1'b0; pend_pc = '0; rd_q = 1'b0; addr_q = '0; pc_r = '0;
    bus.pc = '0; bus.flush = 1'b0; bus.instr_ready = 1'b0;
    bus.imem_rdata = '0;
    for (int i = 0; i < 256; i++)
      mem[i] = 32'h100 + i;
    @(posedge clk);
    #1;

    // streaming with ready held high
    do_reset();
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b0, 1'b1);
    chk("first_valid", 64'(fv), BYP ? 64'd1 : 64'd2);
    chk("stream_n", 64'(acc.size() >= 8), 64'd1);
    for (int i = 0; i < 8 && i < acc.size(); i++)
      chk("stream_pc", 64'(acc[i]), 64'(i));

    // stall: credit limits issues to DEPTH
    do_reset();
    n_iss = 0;
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 1'b0);
    chk("stall_issues", 64'(n_iss), 64'd4);
    chk("stall_pc", 64'(pc_r), 64'd4);
    // full queue: first pop frees credit, issue one cycle later
    n_iss = 0;
    step(1'b0, 1'b0, 1'b1);
    chk("full_pop_noiss", 64'(n_iss), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("full_pop_iss", 64'(n_iss), 64'd1);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b1);
    chk("drain_n", 64'(acc.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < acc.size(); i++)
      chk("drain_pc", 64'(acc[i]), 64'(i));

    // flush with 3 queued and 1 in flight, redirect to 0x40
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    pc_r = 8'h40;
    acc.delete();
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 1'b1);
    chk("flush_n", 64'(acc.size() >= 1), 64'd1);
    if (acc.size() >= 1)
      chk("flush_next_pc", 64'(acc[0]), 64'h40);

    // reset pulse mid-stream
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b0, 1'b1);
    chk("rst_mid_first", 64'(acc.size() >= 1 ? acc[0] : 8'hff), 64'd0);

    // random traffic with occasional flush/reset and random memory
    for (int i = 0; i < 256; i++)
      mem[i] = $urandom;
    for (int i = 0; i < 400; i++) begin
      int rr;
      rr = $urandom_range(0, 99);
      if (rr < 2) begin
        do_reset();
      end else if (rr < 5) begin
        step(1'b0, 1'b1, $urandom_range(0, 1) == 1);
        pc_r = NB'($urandom);
      end else begin
        step(1'b0, 1'b0, $urandom_range(0, 9) < 6);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
